// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered RISC-V immediate generator behind a 2-entry skid buffer.
// Revision 1.0
`default_nettype none

module imm_extend_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [7:0]       illegal_count
);

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_U  = 3'b100;
  localparam logic [2:0] IMM_Z  = 3'b101;
  localparam logic [2:0] IMM_SH = 3'b110;

  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_shamt;
  logic             w_ill;
  logic             w_accept;
  logic             w_out_v_nxt;
  logic             w_skid_v_nxt;
  logic             w_out_load_in;
  logic             w_out_load_skid;
  logic             w_skid_load;

  logic             r_in_ready;
  logic             r_out_v;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;
  logic             r_skid_v;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;
  logic [7:0]       r_ill_cnt;

  // in_instr[k] holds instruction bit k+7
  generate
    if (XLEN == 64) begin : g_shamt64
      assign w_shamt = {{(XLEN-6){1'b0}}, in_instr[18:13]};
    end else begin : g_shamt32
      assign w_shamt = {{(XLEN-5){1'b0}}, in_instr[17:13]};
    end
  endgenerate

  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (in_immsrc)
      IMM_I:  w_imm = {{(XLEN-12){in_instr[24]}}, in_instr[24:13]};
      IMM_S:  w_imm = {{(XLEN-12){in_instr[24]}}, in_instr[24:18], in_instr[4:0]};
      IMM_B:  w_imm = {{(XLEN-12){in_instr[24]}}, in_instr[0], in_instr[23:18],
                       in_instr[4:1], 1'b0};
      IMM_J:  w_imm = {{(XLEN-20){in_instr[24]}}, in_instr[12:5], in_instr[13],
                       in_instr[23:14], 1'b0};
      IMM_U:  w_imm = {{(XLEN-31){in_instr[24]}}, in_instr[23:5], 12'b0};
      IMM_Z:  w_imm = {{(XLEN-5){1'b0}}, in_instr[12:8]};
      IMM_SH: w_imm = w_shamt;
      default: w_ill = 1'b1;
    endcase
  end

  assign w_accept = in_valid & r_in_ready & ~flush;

  // Occupancy: EMPTY (!out_v), ONE (out_v & !skid_v), TWO (skid_v)
  always_comb begin
    w_out_v_nxt     = r_out_v;
    w_skid_v_nxt    = r_skid_v;
    w_out_load_in   = 1'b0;
    w_out_load_skid = 1'b0;
    w_skid_load     = 1'b0;
    if (flush) begin
      w_out_v_nxt  = 1'b0;
      w_skid_v_nxt = 1'b0;
    end else if (r_skid_v) begin
      if (out_ready) begin
        w_out_load_skid = 1'b1;
        w_skid_v_nxt    = 1'b0;
      end
    end else if (r_out_v) begin
      if (out_ready) begin
        w_out_load_in = w_accept;
        w_out_v_nxt   = w_accept;
      end else if (w_accept) begin
        w_skid_load  = 1'b1;
        w_skid_v_nxt = 1'b1;
      end
    end else begin
      w_out_load_in = w_accept;
      w_out_v_nxt   = w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_ready <= 1'b1;
      r_out_v    <= 1'b0;
      r_out_imm  <= '0;
      r_out_tag  <= '0;
      r_out_ill  <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
      r_ill_cnt  <= 8'd0;
    end else begin
      r_out_v    <= w_out_v_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= ~w_skid_v_nxt;
      if (w_out_load_in) begin
        r_out_imm <= w_imm;
        r_out_tag <= in_tag;
        r_out_ill <= w_ill;
      end else if (w_out_load_skid) begin
        r_out_imm <= r_skid_imm;
        r_out_tag <= r_skid_tag;
        r_out_ill <= r_skid_ill;
      end
      if (w_skid_load) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_ill;
      end
      if (w_accept && w_ill && (r_ill_cnt != 8'hFF)) begin
        r_ill_cnt <= r_ill_cnt + 8'd1;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_v;
  assign out_immext    = r_out_imm;
  assign out_tag       = r_out_tag;
  assign out_illegal   = r_out_ill;
  assign illegal_count = r_ill_cnt;

endmodule

`default_nettype wire

// File: doc/imm_extend_stage.md
# imm_extend_stage

Parametrised, registered immediate generator for the decode stage of the 5-stage RISC-V pipeline. Accepts instruction bits [31:7] with an immediate-format select and a sideband tag. Produces the sign- or zero-extended immediate at XLEN width through a 2-entry skid buffer with valid/ready handshakes, flush, and illegal-format reporting. It sits between instruction fetch/decode control and the ID/EX register, and adds U-type, CSR-zimm, shift-amount and illegal formats plus RV64 support.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 5, width of the sideband tag carried with each immediate (e.g. rd).
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has an item.
- in_ready  out  1  block can accept; registered output.
- in_instr  in  25  instruction bits [31:7].
- in_immsrc  in  3  format select (encoding below).
- in_tag  in  TAG_W  sideband, returned unchanged.
- flush  in  1  discard all held and incoming items.
- out_valid  out  1  out_immext/out_tag/out_illegal are valid.
- out_ready  in  1  downstream consumes when high with out_valid.
- out_immext  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the item.
- out_illegal  out  1  item had immsrc 3'b111.
- illegal_count  out  8  saturating count of accepted illegal items.

## Operation
- Formats (S = sign-extend to XLEN, Z = zero-extend):
  - 000 I: S(instr[31:20]).
  - 001 S: S({instr[31:25], instr[11:7]}).
  - 010 B: S({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 J: S({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 100 U: S({instr[31:12], 12'b0}).
  - 101 CSR zimm: Z(instr[19:15]).
  - 110 shamt: Z(instr[24:20]) at XLEN=32; Z(instr[25:20]) at XLEN=64.
  - 111 illegal: immext = 0, illegal = 1.
- Extension is combinational on the input side. The result is captured with tag and illegal flag into the output register (OUT) or the skid register (SKID).
- Accept = in_valid & in_ready & !flush.
- State by occupancy:
  - EMPTY: accept goes to OUT.
  - ONE (OUT full): with out_ready, OUT is replaced by the accepted item, or goes empty if none is accepted. Without out_ready, an accepted item goes to SKID.
  - TWO: in_ready = 0. With out_ready, SKID moves to OUT and SKID clears.
- in_ready is the register value !SKID_valid_next. It is low only in TWO.
- Items leave in acceptance order. There is no combinational path from out_ready to in_ready.
- flush has priority: the next cycle is EMPTY, the same-cycle input is not accepted, and out_valid = 0. illegal_count is unaffected by flush.
- illegal_count increments on each accepted illegal item and saturates at 255. Only reset clears it.

## Timing
- Reset (reset_n low at an edge) gives out_valid = 0, in_ready = 1, out_immext = 0, out_tag = 0, out_illegal = 0, illegal_count = 0.
- in_ready is 1 in the first cycle after reset_n rises.
- Latency is 1 cycle: an item accepted at edge N is on the outputs after edge N with out_valid = 1.
- Throughput is 1 item/cycle while out_ready is held high.
- Output fields stay stable while out_valid & !out_ready.
- Simultaneous accept and consume in ONE: OUT is replaced and the state stays ONE.
- Reset asserted mid-operation drops held items and acts exactly like the reset values above.

## Test plan
- XLEN=32, I-type instr 0xFFF00093 → out_immext 0xFFFFFFFF, out_illegal 0, valid 1 cycle after accept.
- B-type 0xFE000EE3 → 0xFFFFFFFC. J-type 0x0080006F → 0x00000008. U 0x123450B7 → 0x12345000. XLEN=64, U 0x800000B7 → 0xFFFFFFFF80000000.
- Backpressure:
  - out_ready = 0, offer tags 1, 2, 3 back-to-back → 1 and 2 accepted, in_ready drops after the second accept, 3 is held.
  - Raise out_ready → tags emerge in order 1, 2, 3 on consecutive cycles.
- TWO state, assert flush with in_valid high → next cycle out_valid 0, in_ready 1, no item emerges.
- 300 accepted items with immsrc 111 → illegal_count 255, out_immext 0 for each, flush leaves count at 255.
- Assert reset_n low while in TWO → all outputs at reset values next cycle, and the first post-reset item appears with correct latency.
